// File: rtl/instmem_loader.sv
// Instruction memory for the fetch unit: one-cycle registered read port plus a
// byte-stream loader that packs little-endian words sequentially from word 0.
module instmem_loader #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addra,
  output logic [31:0]       douta,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        asm_q, asm_d;
  logic [CNT_W-1:0]   wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [31:0]        douta_q;

  logic               mem_we_c;
  logic [ADDR_W-1:0]  mem_waddr_c;
  logic [31:0]        mem_wdata_c;

  logic [31:0]        mem [DEPTH];

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    wr_addr_d   = wr_addr_q;
    word_cnt_d  = word_cnt_q;
    timer_d     = timer_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr_q[ADDR_W-1:0];
    mem_wdata_c = asm_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          byte_idx_d = '0;
          asm_d      = '0;
          wr_addr_d  = '0;
          word_cnt_d = '0;
          timer_d    = '0;
        end
      end

      ST_LOAD: begin
        if (ld_valid) begin
          timer_d = '0;
          if (wr_addr_q == CNT_W'(DEPTH)) begin
            // Memory already full: the extra byte is dropped and the session aborts.
            state_d = ST_ERR;
          end else begin
            asm_d[{byte_idx_q, 3'b000} +: 8] = ld_data;
            if (byte_idx_q == 2'd3) begin
              mem_we_c    = 1'b1;
              mem_wdata_c = asm_d;
              wr_addr_d   = wr_addr_q + CNT_W'(1);
              word_cnt_d  = word_cnt_q + CNT_W'(1);
              byte_idx_d  = '0;
              asm_d       = '0;
              if (ld_last) begin
                state_d = ST_DONE;
              end
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
              if (ld_last) begin
                state_d = ST_FLUSH;
              end
            end
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_FLUSH: begin
        // Unfilled upper bytes of the assembly register are already zero.
        mem_we_c   = 1'b1;
        word_cnt_d = word_cnt_q + CNT_W'(1);
        byte_idx_d = '0;
        asm_d      = '0;
        state_d    = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and counter state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      asm_q      <= '0;
      wr_addr_q  <= '0;
      word_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      word_cnt_q <= word_cnt_d;
      timer_q    <= timer_d;
    end
  end

  // Read port: registered, read-first against a same-cycle write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      douta_q <= '0;
    end else begin
      douta_q <= mem[addra];
    end
  end

  // Storage array keeps its contents across reset
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign douta     = douta_q;
  assign word_cnt  = word_cnt_q;
  assign ld_ready  = (state_q == ST_LOAD);
  assign cpu_hold  = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign load_done = (state_q == ST_DONE);
  assign load_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_instmem_loader.sv
// Scoreboard bench for instmem_loader on a small 4-word configuration with a
// short byte timeout; read data is predicted from a bench-side memory image.
module tb_instmem_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned DP = 4;
  localparam int unsigned TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [31:0]   douta;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_cnt;

  int            n_vec = 0;
  int            n_err = 0;
  logic [31:0]   model [DP];
  logic [31:0]   exp_q [$];
  logic [7:0]    prog  [8];

  always #5 clock = ~clock;

  instmem_loader #(.ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .addra     (addra),
    .douta     (douta),
    .load_start(load_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    while (!ld_ready && n < 8) begin
      tick();
      n++;
    end
    if (!ld_ready) check("ready_wait", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) begin
      addra = AW'(i);
      exp_q.push_back(model[i]);
      tick();
      check($sformatf("douta[%0d]", i), douta, exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    prog = '{8'h13, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h00, 8'h08};

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_douta", douta, 32'h0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_wcnt", 32'(word_cnt), 32'd0);
    reset = 1'b1;
    tick();

    // Two full words
    start_load();
    check("load_hold", 32'(cpu_hold), 32'd1);
    check("load_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
    check("full_hold", 32'(cpu_hold), 32'd0);
    check("full_done", 32'(load_done), 32'd1);
    check("full_err", 32'(load_err), 32'd0);
    check("full_wcnt", 32'(word_cnt), 32'd2);
    model[0] = 32'h20010013;
    model[1] = 32'h08000008;
    read_words(2);

    // Partial final word goes through a one-cycle flush
    start_load();
    check("part_done_clr", 32'(load_done), 32'd0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    check("flush_hold", 32'(cpu_hold), 32'd1);
    check("flush_ready", 32'(ld_ready), 32'd0);
    check("flush_wcnt", 32'(word_cnt), 32'd0);
    tick();
    check("part_done", 32'(load_done), 32'd1);
    check("part_hold", 32'(cpu_hold), 32'd0);
    check("part_wcnt", 32'(word_cnt), 32'd1);
    model[0] = 32'h00CCBBAA;
    read_words(2);

    // Gapped stream, with a stray load_start mid-session
    start_load();
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], i == 7);
      if (i < 7) begin
        int gap = $urandom_range(1, 6);
        for (int g = 0; g < gap; g++) begin
          load_start = (i == 4 && g == 0);
          tick();
        end
        load_start = 1'b0;
      end
    end
    check("gap_done", 32'(load_done), 32'd1);
    check("gap_wcnt", 32'(word_cnt), 32'd2);
    model[0] = 32'h20010013;
    read_words(2);

    // Timeout after two bytes
    start_load();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (TO - 1) tick();
    check("pre_to_hold", 32'(cpu_hold), 32'd1);
    check("pre_to_err", 32'(load_err), 32'd0);
    tick();
    check("to_err", 32'(load_err), 32'd1);
    check("to_wcnt", 32'(word_cnt), 32'd0);
    check("to_hold", 32'(cpu_hold), 32'd0);
    read_words(1);
    start_load();
    check("restart_err", 32'(load_err), 32'd0);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b1);
    check("restart_done", 32'(load_done), 32'd1);
    model[0] = 32'h11223344;
    read_words(1);

    // Overflow: 16 bytes fill memory, 17th aborts
    start_load();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(i * 17 + 3);
      model[i / 4][8 * (i % 4) +: 8] = b;
      send_byte(b, 1'b0);
    end
    check("ovf_pre_wcnt", 32'(word_cnt), 32'd4);
    check("ovf_pre_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'hEE, 1'b0);
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_wcnt", 32'(word_cnt), 32'd4);
    check("ovf_hold", 32'(cpu_hold), 32'd0);
    read_words(4);

    // Asynchronous reset mid-session
    start_load();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    model[0] = 32'h04030201;
    #2 reset = 1'b0;
    #1;
    check("mrst_hold", 32'(cpu_hold), 32'd0);
    check("mrst_ready", 32'(ld_ready), 32'd0);
    check("mrst_wcnt", 32'(word_cnt), 32'd0);
    check("mrst_douta", douta, 32'h0);
    check("mrst_done", 32'(load_done), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    read_words(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instmem_loader.md
Name: instmem_loader

Overview:
- Instruction-memory responder for the fetch unit: serves 32-bit instruction reads by word address with one-cycle registered latency, matching the block-ROM timing the fetch stage already expects.
- Adds a byte-stream programming port that assembles little-endian words and writes them sequentially from word 0.
- Holds the CPU during loading through cpu_hold.
- Sits between the fetch stage and the board-level UART/byte source.

Parameters:
- ADDR_W, 14, word-address width (64 KB of instruction space).
- DEPTH, 16384, number of 32-bit words; must equal 2**ADDR_W.
- TIMEOUT, 1000000, idle clocks allowed between bytes in LOAD before abort.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- addra  in  ADDR_W  fetch word address (PC[15:2]).
- douta  out  32  instruction word, registered.
- load_start  in  1  one-cycle pulse that begins a programming session.
- ld_valid  in  1  byte-stream valid.
- ld_data  in  8  byte-stream data.
- ld_last  in  1  qualifies the final byte of the session, sampled with ld_valid.
- ld_ready  out  1  byte-stream ready.
- cpu_hold  out  1  high while loading; CPU must stay in reset.
- load_done  out  1  sticky; session completed successfully.
- load_err  out  1  sticky; session aborted (overflow or timeout).
- word_cnt  out  ADDR_W+1  words written in the current/last session.

Behaviour:
- Reset (reset=0, async):
  - douta=0, state=IDLE, ld_ready=0, cpu_hold=0, load_done=0, load_err=0, word_cnt=0.
  - Byte index, assembly register, write address and timeout counter cleared.
  - Memory contents are NOT reset.
- Read port:
  - Every rising edge, douta <= mem[addra]; latency exactly 1 cycle; reads never stall.
  - Reads are served in every state.
  - Read and write to the same address in the same cycle returns OLD data (read-first).
- States: IDLE, LOAD, FLUSH, DONE, ERR.
- IDLE/DONE/ERR:
  - load_start=1 -> LOAD.
  - On entry to LOAD: clear load_done/load_err, wr_addr=0, word_cnt=0, byte_idx=0, assembly=0, timer=0.
- LOAD:
  - ld_ready=1 and cpu_hold=1. A byte is accepted when ld_valid&&ld_ready.
  - Accepted byte goes to assembly[8*byte_idx +: 8] (first byte -> bits 7:0).
  - When byte_idx==3 on accept: write the full word to mem[wr_addr]; wr_addr++, word_cnt++, byte_idx=0, assembly cleared; otherwise byte_idx++.
  - ld_last on accept:
    - byte_idx==3: word written as above, -> DONE.
    - otherwise: -> FLUSH.
  - Overflow: accepting a byte while wr_addr==DEPTH -> no write, -> ERR.
  - Timer increments each LOAD cycle without an accept and resets on accept. Timer reaching TIMEOUT -> ERR; a partially assembled word is discarded.
  - load_start is ignored while in LOAD or FLUSH.
- FLUSH (1 cycle):
  - ld_ready=0, cpu_hold=1.
  - Write the zero-padded partial word to mem[wr_addr]; word_cnt++.
  - -> DONE.
- DONE: load_done=1, cpu_hold=0, ld_ready=0.
- ERR: load_err=1, cpu_hold=0, ld_ready=0; words already written remain in memory.
- cpu_hold: combinational from state (LOAD or FLUSH).
- reset asserted mid-session: immediate return to IDLE. Partially loaded memory is kept; flags and counters are cleared.
- word_cnt width: ADDR_W+1, so DEPTH is representable.

Test Plan:
- Reset then read: assert reset=0, release; addra=0 -> douta=0 until first edge, then mem[0]. Step addra 0,1,2 on consecutive cycles -> douta follows one cycle behind.
- Full-word load: load_start; send bytes 0x13,0x00,0x01,0x20,0x08,0x00,0x00,0x08 with ld_last on the 8th -> mem[0]=0x20010013, mem[1]=0x08000008, word_cnt=2, load_done=1, cpu_hold fell the cycle after the last accept.
- Partial final word: send 0xAA,0xBB,0xCC with ld_last on 0xCC -> FLUSH for one cycle, mem[0]=0x00CCBBAA, word_cnt=1, load_done=1.
- Backpressure/gaps: ld_valid toggles 1,0,0,1 with random gaps shorter than TIMEOUT -> no byte lost or duplicated; assembled words identical to the gap-free run.
- Timeout: TIMEOUT=16; send 2 bytes then idle 16 cycles -> load_err=1, word_cnt=0, mem[0] unchanged. A new load_start clears load_err.
- Overflow and mid-session reset:
  - DEPTH=4: send 17 bytes -> 4 words written, 17th byte -> load_err=1, word_cnt=4.
  - Separately, reset=0 after 5 bytes -> state IDLE, cpu_hold=0, mem[0] retains the first word.
